// File: rtl/demux_write_router_pkg.sv
// Shared definitions for the write router: target indices, FSM encoding,
// default timeout and the target-select decoder.
package demux_write_router_pkg;

    localparam int unsigned DEFAULT_TIMEOUT = 15;

    localparam logic [1:0] TGT_RAM   = 2'd0;
    localparam logic [1:0] TGT_IO    = 2'd1;
    localparam logic [1:0] TGT_TMR   = 2'd2;
    localparam logic [1:0] TGT_SPARE = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Decode a 2-bit target index into the one-hot strobe vector.
    function automatic logic [3:0] tgt_onehot(input logic [1:0] sel);
        logic [3:0] oh;
        case (sel)
            TGT_RAM:   oh = 4'b0001;
            TGT_IO:    oh = 4'b0010;
            TGT_TMR:   oh = 4'b0100;
            TGT_SPARE: oh = 4'b1000;
            default:   oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/demux_write_router_wait_timer.sv
// Wait-state counter for an outstanding write. Counts enabled cycles from
// zero and saturates at TIMEOUT-1, where expire is raised; it never wraps.
module wait_timer
    import demux_write_router_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] count_r;

    // Wait counter: clear on a new write, advance while waiting, hold at LAST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CW{1'b0}};
        end else if (clear) begin
            count_r <= {CW{1'b0}};
        end else if (enable && (count_r != LAST)) begin
            count_r <= count_r + ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign expire = (count_r == LAST);

endmodule

// File: rtl/demux_write_router.sv
// Single-source, four-sink write router. A request is captured while idle,
// strobed to the target chosen by the two top address bits, and held until
// that target acknowledges or the wait timer expires.
module demux_write_router
    import demux_write_router_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
    parameter int unsigned DW      = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic [DW-1:0] addr,
    input  logic [DW-1:0] dat_in,
    output logic          busy,
    output logic [3:0]    wr_en,
    output logic [DW-1:0] addr_out,
    output logic [DW-1:0] dat_out,
    input  logic [3:0]    ack,
    output logic          done,
    output logic          err
);

    state_t     state_r;
    logic [1:0] sel_r;
    logic       ack_sel_s;
    logic       expire_s;
    logic       tmr_clear_s;
    logic       tmr_enable_s;

    // Only the selected target's acknowledge matters; the rest are ignored.
    assign ack_sel_s    = ack[sel_r];
    assign tmr_clear_s  = (state_r == ST_IDLE) && req;
    assign tmr_enable_s = (state_r == ST_WAIT) && !ack_sel_s;
    assign busy         = (state_r == ST_WAIT);

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tmr_clear_s),
        .enable (tmr_enable_s),
        .expire (expire_s)
    );

    // Strobe decodes straight from registered state so reset drops it at once.
    always_comb begin
        if (state_r == ST_WAIT) begin
            wr_en = tgt_onehot(sel_r);
        end else begin
            wr_en = 4'b0000;
        end
    end

    // Request/acknowledge FSM with registered completion pulses and payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            sel_r    <= TGT_RAM;
            addr_out <= {DW{1'b0}};
            dat_out  <= {DW{1'b0}};
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req) begin
                        addr_out <= addr;
                        dat_out  <= dat_in;
                        sel_r    <= addr[DW-1 -: 2];
                        state_r  <= ST_WAIT;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    // Acknowledge takes priority over a simultaneous expiry.
                    if (ack_sel_s) begin
                        state_r <= ST_IDLE;
                        done    <= 1'b1;
                    end else if (expire_s) begin
                        state_r <= ST_IDLE;
                        err     <= 1'b1;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux_write_router.sv
// Self-checking bench for demux_write_router: directed scenarios followed by
// randomized writes checked against a transaction-level expectation.
module tb_demux_write_router;

    localparam int unsigned TO = 15;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [31:0] addr;
    logic [31:0] dat_in;
    logic        busy;
    logic [3:0]  wr_en;
    logic [31:0] addr_out;
    logic [31:0] dat_out;
    logic [3:0]  ack;
    logic [3:0]  ack_r;
    logic        zw_mode;
    logic        done;
    logic        err;

    int n_cmp;
    int n_fail;

    demux_write_router #(
        .TIMEOUT (TO),
        .DW      (32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .addr     (addr),
        .dat_in   (dat_in),
        .busy     (busy),
        .wr_en    (wr_en),
        .addr_out (addr_out),
        .dat_out  (dat_out),
        .ack      (ack),
        .done     (done),
        .err      (err)
    );

    // Zero-wait targets answer combinationally with their strobe.
    assign ack = zw_mode ? wr_en : ack_r;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One write; d = WAIT cycle in which ACK[sel] is raised (0 = never),
    // junk = acknowledges driven on the other targets throughout.
    task automatic run_write(input logic [31:0] a, input logic [31:0] dat,
                             input int d, input logic [3:0] junk);
        logic [3:0] sm;
        logic       exp_done;
        int         exp_len;
        sm       = 4'b0001 << a[31:30];
        exp_done = (d >= 1) && (d <= int'(TO));
        exp_len  = exp_done ? d : int'(TO);
        @(negedge clk);
        req = 1'b1; addr = a; dat_in = dat; ack_r = junk;
        @(posedge clk); #1;
        req = 1'b0; addr = $urandom; dat_in = $urandom;
        for (int c = 1; c <= exp_len; c++) begin
            ack_r = (junk & ~sm) | ((c == d) ? sm : 4'b0000);
            @(negedge clk);
            check("wait_wr_en", {28'd0, wr_en}, {28'd0, sm});
            check("wait_busy", {31'd0, busy}, 32'd1);
            check("wait_done", {31'd0, done}, 32'd0);
            check("wait_err", {31'd0, err}, 32'd0);
            if (c == 1) begin
                check("wait_addr_out", addr_out, a);
                check("wait_dat_out", dat_out, dat);
            end
            @(posedge clk); #1;
        end
        ack_r = 4'($urandom);
        @(negedge clk);
        check("end_wr_en", {28'd0, wr_en}, 32'd0);
        check("end_busy", {31'd0, busy}, 32'd0);
        check("end_done", {31'd0, done}, {31'd0, exp_done});
        check("end_err", {31'd0, err}, {31'd0, !exp_done});
        check("end_addr_out", addr_out, a);
        check("end_dat_out", dat_out, dat);
        @(posedge clk); #1;
        ack_r = 4'b0000;
        @(negedge clk);
        check("post_done", {31'd0, done}, 32'd0);
        check("post_err", {31'd0, err}, 32'd0);
        check("post_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        req     = 1'b0;
        addr    = 32'd0;
        dat_in  = 32'd0;
        ack_r   = 4'b0000;
        zw_mode = 1'b0;

        // Reset state
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_wr_en", {28'd0, wr_en}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_addr_out", addr_out, 32'd0);
        check("rst_dat_out", dat_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait target 0
        run_write(32'h0000_0040, 32'hDEAD_BEEF, 1, 4'b0000);
        // Three wait states on the timer target
        run_write(32'h8000_0004, 32'h1234_5678, 3, 4'b0000);
        // No acknowledge: timeout on the spare target
        run_write(32'hC000_0000, 32'hCAFE_F00D, 0, 4'b0000);
        // Wrong acknowledges, then ACK[1] on the expiry edge: ACK wins
        run_write(32'h4000_0000, 32'hA5A5_5A5A, 15, 4'b1101);

        // Back-to-back with REQ held high and zero-wait targets
        zw_mode = 1'b1;
        @(negedge clk);
        req = 1'b1; addr = 32'h0000_0010; dat_in = 32'h0000_0AAA;
        @(negedge clk);
        check("b2b0_wr_en", {28'd0, wr_en}, 32'h1);
        check("b2b0_busy", {31'd0, busy}, 32'd1);
        addr = 32'h4000_0020; dat_in = 32'h0000_0BBB;
        @(negedge clk);
        check("b2b0_done", {31'd0, done}, 32'd1);
        check("b2b0_busy_low", {31'd0, busy}, 32'd0);
        check("b2b0_no_requeue", addr_out, 32'h0000_0010);
        check("b2b0_dat_out", dat_out, 32'h0000_0AAA);
        @(negedge clk);
        check("b2b1_wr_en", {28'd0, wr_en}, 32'h2);
        check("b2b1_addr_out", addr_out, 32'h4000_0020);
        check("b2b1_done_low", {31'd0, done}, 32'd0);
        addr = 32'h8000_0030; dat_in = 32'h0000_0CCC;
        @(negedge clk);
        check("b2b1_done", {31'd0, done}, 32'd1);
        check("b2b1_dat_out", dat_out, 32'h0000_0BBB);
        @(negedge clk);
        check("b2b2_wr_en", {28'd0, wr_en}, 32'h4);
        req = 1'b0;
        @(negedge clk);
        check("b2b2_done", {31'd0, done}, 32'd1);
        check("b2b2_dat_out", dat_out, 32'h0000_0CCC);
        @(negedge clk);
        check("b2b_idle_busy", {31'd0, busy}, 32'd0);
        check("b2b_idle_done", {31'd0, done}, 32'd0);
        zw_mode = 1'b0;

        // Randomized writes against the transaction-level expectation
        for (int i = 0; i < 24; i++) begin
            run_write($urandom, $urandom, $urandom_range(0, TO + 2), 4'($urandom));
        end

        // Reset in the middle of a write to the I/O target
        @(negedge clk);
        req = 1'b1; addr = 32'h4000_0008; dat_in = 32'h5555_AAAA; ack_r = 4'b0000;
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        check("mid_wr_en", {28'd0, wr_en}, 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", {28'd0, wr_en}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_err", {31'd0, err}, 32'd0);
        check("mid_rst_addr_out", addr_out, 32'd0);
        check("mid_rst_dat_out", dat_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < int'(TO) + 2; i++) begin
            @(negedge clk);
            check("post_rst_done", {31'd0, done}, 32'd0);
            check("post_rst_err", {31'd0, err}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_write_router.md
# demux_write_router

Routes a single 32-bit write request from the processor's memory stage to exactly one of four downstream targets (data RAM, I/O registers, timer, spare), selected by the top two address bits. It is the fan-out counterpart of the datapath's 2:1 word selectors: one source, many sinks. Each write is registered, held until the selected target acknowledges, and bounded by a timeout that flags unresponsive targets.

## Interface
- TIMEOUT, 15: maximum cycles WR_EN is held waiting for ACK; legal range 1..255
- DW, 32: data and address width
- CLK  in  1  rising-edge clock
- RST_N  in  1  reset, asynchronous, active-low
- REQ  in  1  write request valid; accepted only in a cycle where BUSY=0
- ADDR  in  DW  write address; ADDR[31:30] selects target
- DAT_IN  in  DW  write data
- BUSY  out  1  high while a write is outstanding
- WR_EN  out  4  one-hot write strobe, bit i to target i
- ADDR_OUT  out  DW  registered address, shared by all targets
- DAT_OUT  out  DW  registered data, shared by all targets
- ACK  in  4  per-target acknowledge, bit i from target i
- DONE  out  1  one-cycle pulse: write acknowledged
- ERR  out  1  one-cycle pulse: write timed out

## Operation
- States: IDLE, WAIT. BUSY = (state == WAIT).
- IDLE, REQ=1 at edge: capture ADDR, DAT_IN into ADDR_OUT, DAT_OUT; capture SEL=ADDR[31:30]; clear wait counter; go to WAIT. REQ=0: stay.
- WAIT: WR_EN = one-hot(SEL); other bits 0. Each edge:
  - ACK[SEL]=1: go IDLE, DONE=1 next cycle.
  - else counter == TIMEOUT-1: go IDLE, ERR=1 next cycle.
  - else counter += 1.
- ACK bits other than ACK[SEL] ignored at all times; any ACK in IDLE ignored.
- ACK[SEL] and timeout expiry at the same edge: ACK wins (DONE, no ERR).
- REQ while BUSY=1: ignored, not queued; source must hold REQ until it samples BUSY=0.
- DONE and ERR mutually exclusive; each high for exactly one cycle.
- ADDR_OUT, DAT_OUT hold the last captured values after completion; not cleared.
- Counter width: ceil(log2(TIMEOUT+1)) bits; never wraps.

## Timing
- Reset (RST_N=0, async): state IDLE, BUSY=0, WR_EN=0, DONE=0, ERR=0, ADDR_OUT=0, DAT_OUT=0, counter=0.
- Reset mid-write: WR_EN drops immediately, no DONE/ERR is produced, write is lost.
- REQ accepted at edge k: BUSY=1 and WR_EN[SEL]=1 from cycle k+1.
- ACK[SEL] sampled at edge k+n (n>=1): WR_EN=0, BUSY=0, DONE=1 in cycle k+n+1.
- Zero-wait target (ACK combinational with WR_EN): n=1, DONE in cycle k+2.
- New REQ may be accepted at the edge ending the DONE/ERR cycle; max throughput one write per 2 cycles.
- No ACK: WR_EN held exactly TIMEOUT cycles; ERR=1 in cycle k+TIMEOUT+1.
- All outputs registered except WR_EN, which decodes from registered state and SEL.

## Structure
- Shared package/include: target index constants TGT_RAM=0, TGT_IO=1, TGT_TMR=2, TGT_SPARE=3; state encoding IDLE=0, WAIT=1; default TIMEOUT.
- One sub-module: wait_timer (clear, enable, expire output, parameter TIMEOUT), instantiated once.

## Test plan
- Reset: RST_N=0 mid-WAIT with WR_EN=4'b0010 -> WR_EN=0, BUSY=0, DONE=0, ERR=0, ADDR_OUT=0, DAT_OUT=0 before next edge.
- Zero-wait: REQ, ADDR=32'h0000_0040, DAT_IN=32'hDEAD_BEEF, ACK[0] tied to WR_EN[0] -> WR_EN=4'b0001 one cycle, DAT_OUT=32'hDEAD_BEEF, DONE in cycle k+2.
- Wait states: ADDR=32'h8000_0004, ACK[2] after 3 cycles -> WR_EN=4'b0100 for 3 cycles, DONE one cycle later, ERR never.
- Timeout: ADDR=32'hC000_0000, ACK=0, TIMEOUT=15 -> WR_EN=4'b1000 for 15 cycles, ERR in cycle k+16, DONE never.
- Wrong ACK and tie: ADDR=32'h4000_0000, ACK=4'b1101 for 14 cycles, then ACK[1] at cycle 15 -> no early completion; DONE (not ERR) in cycle k+16.
- Back-to-back: REQ held high, writes to targets 0,1,2 with zero-wait ACK -> one write per 2 cycles, second REQ not accepted while BUSY=1, three DONE pulses.
